// File: rtl/imem_ctrl_pkg.sv
// Shared constants, state encodings and address check for the instruction-memory port arbiter.
// Pure declarations: no latency, no backpressure.
package imem_ctrl_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_sel_t;

  // Word accesses only, and nothing beyond the end of the array.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and memory-array signal bundle of the arbiter; slave = arbiter side.
// Fetch responses use valid/ready; loader and memory sides are single-cycle strobes.
interface imem_port_arbiter_if;
  import imem_ctrl_pkg::*;

  logic          f_req_i;
  logic [31:0]   f_addr_i;
  logic          f_gnt_o;
  logic          f_rvalid_o;
  logic [31:0]   f_rdata_o;
  logic          f_err_o;
  logic          f_rready_i;

  logic          l_req_i;
  logic [31:0]   l_addr_i;
  logic [31:0]   l_wdata_i;
  logic          l_gnt_o;
  logic          l_done_o;
  logic          l_err_o;

  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  modport slave (
    input  f_req_i, f_addr_i, f_rready_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
    input  l_req_i, l_addr_i, l_wdata_i,
    output l_gnt_o, l_done_o, l_err_o,
    output mem_addr_o, mem_we_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output f_req_i, f_addr_i, f_rready_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
    output l_req_i, l_addr_i, l_wdata_i,
    input  l_gnt_o, l_done_o, l_err_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer remembers the last winner.
// Zero latency; a requester that is not eligible is simply never granted.
module rr_arb2
  import imem_ctrl_pkg::*;
(
  input  logic       core_clk,
  input  logic       arst_n,
  input  logic [1:0] req,
  input  logic [1:0] eligible,
  output logic [1:0] gnt
);

  req_sel_t   last_q;
  logic [1:0] act;

  assign act = req & eligible;

  always_comb begin
    gnt = act;
    if (act == 2'b11) begin
      gnt = (last_q == REQ_LOAD) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      last_q <= REQ_FETCH;
    end else if (gnt[1]) begin
      last_q <= REQ_LOAD;
    end else if (gnt[0]) begin
      last_q <= REQ_FETCH;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one combinational-read memory between fetch (read, 1-cycle registered response) and loader (write).
// Fetch is held off only while its single response slot is full and not being drained.
module imem_port_arbiter
  import imem_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  imem_port_arbiter_if.slave    bus
);

  slot_state_t slot_q, slot_d;
  logic [1:0]  req, elig, gnt;
  logic        f_acc, l_acc, f_bad, l_bad;
  logic [31:0] rdata_q;
  logic        err_q, done_q, lerr_q;

  assign f_bad = addr_bad(bus.f_addr_i);
  assign l_bad = addr_bad(bus.l_addr_i);

  // A full slot still admits a new fetch when it drains in the same cycle.
  assign req  = {bus.l_req_i, bus.f_req_i};
  assign elig = {1'b1, (slot_q == SLOT_EMPTY) || bus.f_rready_i};

  rr_arb2 u_arb (
    .core_clk (clk_i),
    .arst_n   (rst_i),
    .req      (req),
    .eligible (elig),
    .gnt      (gnt)
  );

  assign f_acc = gnt[0];
  assign l_acc = gnt[1];

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (f_acc) slot_d = SLOT_FULL;
      SLOT_FULL:  if (!f_acc && bus.f_rready_i) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_wdata_o = '0;
    if (f_acc) begin
      bus.mem_addr_o = bus.f_addr_i[AW+1:2];
    end else if (l_acc) begin
      bus.mem_addr_o  = bus.l_addr_i[AW+1:2];
      bus.mem_we_o    = !l_bad;
      bus.mem_wdata_o = bus.l_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      if (f_acc) begin
        rdata_q <= f_bad ? 32'h0 : bus.mem_rdata_i;
        err_q   <= f_bad;
      end
      done_q <= l_acc;
      lerr_q <= l_acc && l_bad;
    end
  end

  assign bus.f_gnt_o    = f_acc;
  assign bus.l_gnt_o    = l_acc;
  assign bus.f_rvalid_o = (slot_q == SLOT_FULL);
  assign bus.f_rdata_o  = rdata_q;
  assign bus.f_err_o    = err_q;
  assign bus.l_done_o   = done_q;
  assign bus.l_err_o    = lerr_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed vector table, reset corner cases and a randomized run against a transaction-level model.
module tb_imem_port_arbiter;
  import imem_ctrl_pkg::*;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  imem_port_arbiter_if bus();

  imem_port_arbiter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Memory array the arbiter fronts: combinational read, write at the edge.
  logic [31:0] mem_arr [DEPTH];
  logic        mem_init_req;
  always @(posedge clk_i) begin
    if (mem_init_req) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_val(i);
    end else if (bus.mem_we_o) begin
      mem_arr[bus.mem_addr_o] <= bus.mem_wdata_o;
    end
  end
  assign bus.mem_rdata_i = mem_arr[bus.mem_addr_o];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      1:       return $urandom | 32'h0000_0080;
      default: return 32'($urandom_range(0, DEPTH - 1) * 4);
    endcase
  endfunction

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        rr;
    logic        l_req;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        e_fgnt;
    logic        e_lgnt;
    logic        e_we;
    logic [31:0] e_maddr;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_ferr;
    logic        e_done;
    logic        e_lerr;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  task automatic drive(input logic fr, input logic [31:0] fa, input logic rr,
                       input logic lr, input logic [31:0] la, input logic [31:0] lw);
    bus.f_req_i    = fr;
    bus.f_addr_i   = fa;
    bus.f_rready_i = rr;
    bus.l_req_i    = lr;
    bus.l_addr_i   = la;
    bus.l_wdata_i  = lw;
  endtask

  logic [31:0] ref_mem [DEPTH];
  logic        m_full, m_err, m_last_load, fr, rr, lr, f_ok, gf, gl;
  logic [31:0] m_data, fa, la, lw, e_maddr;

  initial begin
    vt[0]  = '{Y, 32'h00, Y, N, 32'h00, 32'h0, Y, N, N, 32'd0,  Y, init_val(0), N, N, N};
    vt[1]  = '{Y, 32'h04, Y, N, 32'h00, 32'h0, Y, N, N, 32'd1,  Y, init_val(1), N, N, N};
    vt[2]  = '{Y, 32'h08, Y, N, 32'h00, 32'h0, Y, N, N, 32'd2,  Y, init_val(2), N, N, N};
    vt[3]  = '{Y, 32'h0C, Y, N, 32'h00, 32'h0, Y, N, N, 32'd3,  Y, init_val(3), N, N, N};
    vt[4]  = '{Y, 32'h10, Y, Y, 32'h44, 32'h1111_0000, N, Y, Y, 32'd17, N, 32'h0, N, Y, N};
    vt[5]  = '{Y, 32'h10, Y, Y, 32'h48, 32'h2222_0000, Y, N, N, 32'd4,  Y, init_val(4), N, N, N};
    vt[6]  = '{Y, 32'h14, Y, Y, 32'h48, 32'h2222_0000, N, Y, Y, 32'd18, N, 32'h0, N, Y, N};
    vt[7]  = '{Y, 32'h14, Y, Y, 32'h4C, 32'h2222_0000, Y, N, N, 32'd5,  Y, init_val(5), N, N, N};
    vt[8]  = '{Y, 32'h18, N, N, 32'h00, 32'h0, N, N, N, 32'd0,  Y, init_val(5), N, N, N};
    vt[9]  = '{Y, 32'h18, N, Y, 32'h50, 32'h1234_5678, N, Y, Y, 32'd20, Y, init_val(5), N, Y, N};
    vt[10] = '{Y, 32'h18, N, N, 32'h00, 32'h0, N, N, N, 32'd0,  Y, init_val(5), N, N, N};
    vt[11] = '{N, 32'h00, Y, Y, 32'h10, 32'hDEAD_BEEF, N, Y, Y, 32'd4, N, 32'h0, N, Y, N};
    vt[12] = '{Y, 32'h10, Y, N, 32'h00, 32'h0, Y, N, N, 32'd4,  Y, 32'hDEAD_BEEF, N, N, N};
    vt[13] = '{Y, 32'h44, Y, N, 32'h00, 32'h0, Y, N, N, 32'd17, Y, 32'h1111_0000, N, N, N};
    vt[14] = '{Y, 32'h50, Y, N, 32'h00, 32'h0, Y, N, N, 32'd20, Y, 32'h1234_5678, N, N, N};
    vt[15] = '{Y, 32'h06, Y, N, 32'h00, 32'h0, Y, N, N, 32'd1,  Y, 32'h0, Y, N, N};
    vt[16] = '{Y, 32'h80, Y, N, 32'h00, 32'h0, Y, N, N, 32'd0,  Y, 32'h0, Y, N, N};
    vt[17] = '{N, 32'h00, Y, Y, 32'h80, 32'hCAFE_F00D, N, Y, N, 32'd0, N, 32'h0, N, Y, Y};
    vt[18] = '{Y, 32'h00, Y, N, 32'h00, 32'h0, Y, N, N, 32'd0,  Y, init_val(0), N, N, N};

    // Reset state, with the memory array loaded during reset.
    rst_i = 1'b0;
    mem_init_req = 1'b1;
    drive(N, 32'h0, N, N, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    mem_init_req = 1'b0;
    chk1 ("rst_f_rvalid", bus.f_rvalid_o, 1'b0);
    chk32("rst_f_rdata",  bus.f_rdata_o,  32'h0);
    chk1 ("rst_f_err",    bus.f_err_o,    1'b0);
    chk1 ("rst_l_done",   bus.l_done_o,   1'b0);
    chk1 ("rst_l_err",    bus.l_err_o,    1'b0);
    chk1 ("rst_mem_we",   bus.mem_we_o,   1'b0);
    rst_i = 1'b1;

    for (int v = 0; v < NV; v++) begin
      drive(vt[v].f_req, vt[v].f_addr, vt[v].rr, vt[v].l_req, vt[v].l_addr, vt[v].l_wdata);
      @(negedge clk_i);
      chk1 ($sformatf("v%0d_f_gnt", v),    bus.f_gnt_o,    vt[v].e_fgnt);
      chk1 ($sformatf("v%0d_l_gnt", v),    bus.l_gnt_o,    vt[v].e_lgnt);
      chk1 ($sformatf("v%0d_mem_we", v),   bus.mem_we_o,   vt[v].e_we);
      chk32($sformatf("v%0d_mem_addr", v), 32'(bus.mem_addr_o), vt[v].e_maddr);
      if (vt[v].e_lgnt)
        chk32($sformatf("v%0d_mem_wdata", v), bus.mem_wdata_o, vt[v].l_wdata);
      else if (!vt[v].e_fgnt)
        chk32($sformatf("v%0d_idle_wdata", v), bus.mem_wdata_o, 32'h0);
      @(posedge clk_i);
      #1;
      chk1($sformatf("v%0d_f_rvalid", v), bus.f_rvalid_o, vt[v].e_rvalid);
      if (vt[v].e_rvalid) begin
        chk32($sformatf("v%0d_f_rdata", v), bus.f_rdata_o, vt[v].e_rdata);
        chk1 ($sformatf("v%0d_f_err", v),   bus.f_err_o,   vt[v].e_ferr);
      end
      chk1($sformatf("v%0d_l_done", v), bus.l_done_o, vt[v].e_done);
      chk1($sformatf("v%0d_l_err", v),  bus.l_err_o,  vt[v].e_lerr);
    end

    // Reset asserted between edges while a response is held: it vanishes at once.
    drive(N, 32'h0, N, N, 32'h0, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    chk1 ("async_rst_f_rvalid", bus.f_rvalid_o, 1'b0);
    chk32("async_rst_f_rdata",  bus.f_rdata_o,  32'h0);
    chk1 ("async_rst_f_err",    bus.f_err_o,    1'b0);
    mem_init_req = 1'b1;
    @(posedge clk_i);
    #1;
    mem_init_req = 1'b0;
    rst_i = 1'b1;

    // Pointer back at FETCH after reset: loader wins a tie.
    drive(Y, 32'h0, Y, Y, 32'h3, 32'hCAFE_F00D);
    @(negedge clk_i);
    chk1("ptr_rst_l_gnt", bus.l_gnt_o, 1'b1);
    chk1("ptr_rst_f_gnt", bus.f_gnt_o, 1'b0);
    chk1("ptr_rst_we",    bus.mem_we_o, 1'b0);
    @(posedge clk_i);
    #1;
    chk1("ptr_rst_l_done",   bus.l_done_o,   1'b1);
    chk1("ptr_rst_l_err",    bus.l_err_o,    1'b1);
    chk1("ptr_rst_f_rvalid", bus.f_rvalid_o, 1'b0);

    // Randomized run against a transaction-level model.
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    m_full = 1'b0;
    m_err = 1'b0;
    m_data = 32'h0;
    m_last_load = 1'b1;
    for (int c = 0; c < 600; c++) begin
      fr = 1'($urandom_range(0, 3) != 0);
      rr = 1'($urandom_range(0, 2) != 0);
      lr = 1'($urandom_range(0, 2) == 0);
      fa = rnd_addr();
      la = rnd_addr();
      lw = $urandom;
      drive(fr, fa, rr, lr, la, lw);

      f_ok = fr && (!m_full || rr);
      if (f_ok && lr) begin
        gf = m_last_load;
        gl = !m_last_load;
      end else begin
        gf = f_ok;
        gl = lr;
      end
      e_maddr = gf ? 32'(word_of(fa)) : (gl ? 32'(word_of(la)) : 32'h0);

      @(negedge clk_i);
      chk1 ("rnd_f_gnt",    bus.f_gnt_o,  gf);
      chk1 ("rnd_l_gnt",    bus.l_gnt_o,  gl);
      chk1 ("rnd_mem_we",   bus.mem_we_o, gl && !is_bad(la));
      chk32("rnd_mem_addr", 32'(bus.mem_addr_o), e_maddr);

      if (gf) begin
        m_full = 1'b1;
        m_err  = is_bad(fa);
        m_data = is_bad(fa) ? 32'h0 : ref_mem[word_of(fa)];
      end else if (m_full && rr) begin
        m_full = 1'b0;
      end
      if (gl && !is_bad(la)) ref_mem[word_of(la)] = lw;
      if (gf) m_last_load = 1'b0;
      if (gl) m_last_load = 1'b1;

      @(posedge clk_i);
      #1;
      chk1("rnd_f_rvalid", bus.f_rvalid_o, m_full);
      if (m_full) begin
        chk32("rnd_f_rdata", bus.f_rdata_o, m_data);
        chk1 ("rnd_f_err",   bus.f_err_o,   m_err);
      end
      chk1("rnd_l_done", bus.l_done_o, gl);
      chk1("rnd_l_err",  bus.l_err_o,  gl && is_bad(la));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
